mod5_frame_tx: RTL

//  Serial transmitter, the sending end of the divisible-by-5 serial check link.

---
 rtl/mod5_pkg.sv | 25 ++
 rtl/mod5_rem_tracker.sv | 24 ++
 rtl/mod5_frame_tx.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mod5_pkg.sv
// Shared types and arithmetic for the divisible-by-5 serial link.
// Both the transmitter and the receiving side use the same remainder recurrence.
package mod5_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        CHK
    } state_t;

    localparam int CHK_W = 3;

    // (2*rem + b) mod 5; {rem,b} is exactly 2*rem+b, which is at most 9.
    function automatic logic [2:0] rem_next(input logic [2:0] rem, input logic b);
        logic [3:0] t;
        t = {rem, b};
        return (t >= 4'd5) ? 3'(t - 4'd5) : t[2:0];
    endfunction

    // Check field that returns the frame remainder to 0 after three more bits.
    function automatic logic [CHK_W-1:0] chk_of(input logic [2:0] rem);
        return rem_next(rem, 1'b0);
    endfunction

endpackage

// File: rtl/mod5_rem_tracker.sv
// Running remainder mod 5 of a bit stream received MSB-first.
// clear has priority over en and restarts the value at 0.
module mod5_rem_tracker
    import mod5_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       clear,
    input  logic       en,
    input  logic       din,
    output logic [2:0] rem
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem <= 3'd0;
        end else if (clear) begin
            rem <= 3'd0;
        end else if (en) begin
            rem <= rem_next(rem, din);
        end
    end

endmodule

// File: rtl/mod5_frame_tx.sv
// Serial frame transmitter: DATA_W payload bits MSB-first, then a 3-bit check field
// chosen so that every frame, and therefore every concatenation of frames, is divisible by 5.
module mod5_frame_tx
    import mod5_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              sout,
    output logic              sout_valid,
    output logic              sof,
    output logic              eof
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_t             state;
    state_t             state_next;
    logic [DATA_W-1:0]  shreg;
    logic [CNT_W-1:0]   bit_cnt;
    logic [1:0]         chk_cnt;
    logic [CHK_W-1:0]   chk;
    logic [CHK_W-1:0]   chk_new;
    logic [2:0]         rem;
    logic               accept;
    logic               last_bit;
    logic               rem_en;

    assign in_ready = (state == IDLE) || (state == CHK && chk_cnt == 2'd2);

    mod5_rem_tracker u_rem (
        .clk    (clk),
        .resetn (resetn),
        .clear  (accept),
        .en     (rem_en),
        .din    (shreg[DATA_W-1]),
        .rem    (rem)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        accept     = in_valid && in_ready;
        last_bit   = (bit_cnt == LAST_BIT);
        rem_en     = (state == DATA);
        // The check field must cover the last data bit, which is still being shifted in.
        chk_new    = chk_of(rem_next(rem, shreg[DATA_W-1]));
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = DATA;
            DATA: if (last_bit) state_next = CHK;
            CHK: begin
                if (chk_cnt == 2'd2) begin
                    state_next = accept ? DATA : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output registers hold the bit that goes on the wire during the following cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            chk_cnt    <= 2'd0;
            chk        <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            sof        <= 1'b0;
            eof        <= 1'b0;
        end else begin
            sof <= 1'b0;
            eof <= 1'b0;
            if (accept) begin
                shreg      <= in_data;
                bit_cnt    <= '0;
                chk_cnt    <= 2'd0;
                sout       <= in_data[DATA_W-1];
                sout_valid <= 1'b1;
                sof        <= 1'b1;
            end else begin
                case (state)
                    DATA: begin
                        shreg <= shreg << 1;
                        if (last_bit) begin
                            bit_cnt <= '0;
                            chk_cnt <= 2'd0;
                            chk     <= chk_new;
                            sout    <= chk_new[CHK_W-1];
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            sout    <= shreg[DATA_W-2];
                        end
                    end
                    CHK: begin
                        if (chk_cnt == 2'd2) begin
                            chk_cnt    <= 2'd0;
                            sout       <= 1'b0;
                            sout_valid <= 1'b0;
                        end else begin
                            chk_cnt <= chk_cnt + 1'b1;
                            sout    <= (chk_cnt == 2'd0) ? chk[1] : chk[0];
                            eof     <= (chk_cnt == 2'd1);
                        end
                    end
                    default: begin
                        sout       <= 1'b0;
                        sout_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
